posdf_sweep_ctrl: RTL
=====================

Name: posdf_sweep_ctrl

Overview:
Self-test sequencer for the 3-input POS logic unit (inputs a, b, d; output y). On a start pulse it drives all 2^N_IN input vectors in ascending order and waits a programmable settle time per vector. It samples y into a captured truth table and compares that table against an expected table. It sits between the bench or a host-side control register and the POS unit, and gives a start/busy/done handshake plus pass/fail results.

Parameters:
N_IN, 3, number of unit inputs; vector order {a,b,d}, a = MSB; table width TT_W = 2^N_IN
SETTLE_CYCLES, 2, cycles each vector is held before sampling; legal range 1..255

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  begin sweep; sampled only in IDLE
abort  input  1  synchronous cancel; any state goes to IDLE
expect_tt  input  TT_W  expected truth table, bit k = y for vector k; latched on accepted start
dut_y  input  1  output of the POS unit
vec  output  N_IN  vector driven to the unit (a=vec[2], b=vec[1], d=vec[0])
busy  output  1  high from the cycle after an accepted start until done
done  output  1  one-cycle pulse when the sweep completes
pass  output  1  captured table == latched expect; valid from done, held until next start
tt_out  output  TT_W  captured truth table; held until next start
fail_idx  output  N_IN  lowest mismatching vector index; 0 when pass
fail_valid  output  1  high when pass=0 after done

Behaviour:
- Reset (async, rst=1): state=IDLE; vec=0, busy=0, done=0, pass=0, tt_out=0, fail_idx=0, fail_valid=0; settle counter=0, idx=0.
- FSM states: IDLE, SETTLE, SAMPLE, DONE. All outputs are registered.
- IDLE: vec=0. When start=1 at an edge:
  - expect_tt is latched; tt_out, pass, fail_idx and fail_valid are cleared.
  - idx=0, cnt=SETTLE_CYCLES-1, next state SETTLE, busy=1.
- SETTLE: vec=idx.
  - Each cycle, if cnt==0 go to SAMPLE, else cnt--.
  - This holds the vector for exactly SETTLE_CYCLES cycles.
- SAMPLE: vec=idx is still driven; tt_out[idx] <= dut_y.
  - If idx==TT_W-1, go to DONE.
  - Otherwise idx++, cnt reloads to SETTLE_CYCLES-1, go to SETTLE.
- DONE, one cycle:
  - done=1, busy=0.
  - pass = (tt_out==expect_latched).
  - fail_idx = lowest k with a mismatch; fail_valid = !pass.
  - Next state IDLE; vec returns to 0.
- Latency: each vector takes SETTLE_CYCLES+1 cycles. If start is accepted at edge 0, vector k is sampled at edge (k+1)*(SETTLE_CYCLES+1). done is high in the cycle following edge TT_W*(SETTLE_CYCLES+1); with defaults that is 24.
- start while busy or in DONE: ignored, no queueing.
- abort has priority over start and over every FSM transition.
  - Next state IDLE, busy=0, done is not pulsed.
  - tt_out keeps the partial capture; pass=0, fail_valid=0.
- abort and start in the same IDLE cycle: abort wins and the sweep does not begin.
- Reset asserted mid-sweep: immediate asynchronous return to reset values.
- idx wrap: idx never increments past TT_W-1.
- Changing expect_tt during a sweep has no effect, because only the latched copy is compared.
- dut_y is treated as synchronous to clk. The settle time covers unit propagation; no synchroniser is included.

Decomposition:
- posdf_pkg (shared localparam include): state encodings ST_IDLE=2'd0, ST_SETTLE=2'd1, ST_SAMPLE=2'd2, ST_DONE=2'd3; default N_IN, SETTLE_CYCLES.
- Sub-module posdf_settle_timer: 8-bit down-counter with load/zero flag, reusable by other sweep controllers.
- Mismatch priority encoder stays inline as a combinational loop over TT_W bits.

Test Plan:
1. Bench POS model y=(a|b)&(~a|d) on vec, expect_tt=8'hAC, start pulse -> vec steps 0..7, each held 3 cycles; done at cycle 24; tt_out=8'hAC, pass=1, fail_valid=0.
2. Same model, expect_tt=8'hAD -> done at cycle 24; tt_out=8'hAC, pass=0, fail_valid=1, fail_idx=0.
3. abort=1 while vec=3 -> next cycle busy=0, vec=0, no done pulse; tt_out bits [2:0] hold captured values (bit2=1), pass=0.
4. start re-pulsed at cycle 10 mid-sweep -> ignored; done still at cycle 24 with the unchanged result 8'hAC.
5. rst=1 asynchronously mid-SETTLE at vec=5 -> all outputs 0 immediately without a clock edge; a new start after release runs a full, correct sweep.
6. SETTLE_CYCLES=1 and dut_y tied to 1 with expect_tt=8'hFF -> vector period 2 cycles, done at cycle 16, tt_out=8'hFF, pass=1.

Source files
------------

// File: rtl/posdf_pkg.sv
// posdf_pkg: shared state encodings and default parameters for the POS sweep controller
package posdf_pkg;
  localparam int N_IN_DEF = 3;
  localparam int SETTLE_DEF = 2;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;
endpackage

// File: rtl/posdf_sweep_ctrl_if.sv
// posdf_sweep_ctrl_if: host/unit handshake and result bus of the sweep controller
interface posdf_sweep_ctrl_if import posdf_pkg::*; #(parameter int N_IN = N_IN_DEF) ();
  localparam int TT_W = 1 << N_IN;
  logic start;
  logic abort;
  logic [TT_W-1:0] expect_tt;
  logic dut_y;
  logic [N_IN-1:0] vec;
  logic busy;
  logic done;
  logic pass;
  logic [TT_W-1:0] tt_out;
  logic [N_IN-1:0] fail_idx;
  logic fail_valid;
  modport master (output start, abort, expect_tt, dut_y,
                  input vec, busy, done, pass, tt_out, fail_idx, fail_valid);
  modport slave (input start, abort, expect_tt, dut_y,
                 output vec, busy, done, pass, tt_out, fail_idx, fail_valid);
endinterface

// File: rtl/posdf_settle_timer.sv
// posdf_settle_timer: 8-bit loadable down-counter with zero flag
module posdf_settle_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       dec,
  input  logic [7:0] load_val,
  output logic       zero
);
  logic [7:0] cnt;
  assign zero = cnt == 8'd0;
  // load wins over decrement; decrement saturates at zero
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= 8'd0;
    else if (load) cnt <= load_val;
    else if (dec && !zero) cnt <= cnt - 8'd1;
endmodule

// File: rtl/posdf_sweep_ctrl.sv
// posdf_sweep_ctrl: exhaustive truth-table sweep and compare for the POS unit
module posdf_sweep_ctrl import posdf_pkg::*; #(
  parameter int N_IN = N_IN_DEF,
  parameter int SETTLE_CYCLES = SETTLE_DEF
) (
  input logic clk,
  input logic rst,
  posdf_sweep_ctrl_if.slave bus
);
  localparam int TT_W = 1 << N_IN;
  localparam logic [7:0] RELOAD = 8'(SETTLE_CYCLES - 1);
  logic [1:0] state;
  logic [N_IN-1:0] idx, fi;
  logic [TT_W-1:0] exp_l, cap, diff;
  logic zero, load, dec, last, accept;
  assign accept = state == ST_IDLE && bus.start && !bus.abort;
  assign last = idx == N_IN'(TT_W - 1);
  assign load = accept || (state == ST_SAMPLE && !last && !bus.abort);
  assign dec = state == ST_SETTLE;
  assign diff = cap ^ exp_l;
  posdf_settle_timer u_timer (
    .clk(clk),
    .rst(rst),
    .load(load),
    .dec(dec),
    .load_val(RELOAD),
    .zero(zero)
  );
  // table including the bit being sampled this cycle, so the verdict is ready with done
  always_comb begin
    cap = bus.tt_out;
    cap[idx] = bus.dut_y;
  end
  // lowest mismatching vector wins
  always_comb begin
    fi = '0;
    for (int k = TT_W - 1; k >= 0; k--) if (diff[k]) fi = N_IN'(k);
  end
  // sweep FSM with registered outputs; abort overrides every transition
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= ST_IDLE;
      idx <= '0;
      exp_l <= '0;
      bus.vec <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.pass <= 1'b0;
      bus.tt_out <= '0;
      bus.fail_idx <= '0;
      bus.fail_valid <= 1'b0;
    end else if (bus.abort) begin
      state <= ST_IDLE;
      bus.vec <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.pass <= 1'b0;
      bus.fail_valid <= 1'b0;
    end else
      case (state)
        ST_IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            exp_l <= bus.expect_tt;
            bus.tt_out <= '0;
            bus.pass <= 1'b0;
            bus.fail_idx <= '0;
            bus.fail_valid <= 1'b0;
            idx <= '0;
            bus.vec <= '0;
            bus.busy <= 1'b1;
            state <= ST_SETTLE;
          end
        end
        ST_SETTLE: if (zero) state <= ST_SAMPLE;
        ST_SAMPLE: begin
          bus.tt_out <= cap;
          if (last) begin
            state <= ST_DONE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            bus.pass <= ~|diff;
            bus.fail_idx <= fi;
            bus.fail_valid <= |diff;
          end else begin
            idx <= idx + 1'b1;
            bus.vec <= idx + 1'b1;
            state <= ST_SETTLE;
          end
        end
        default: begin
          bus.done <= 1'b0;
          bus.vec <= '0;
          state <= ST_IDLE;
        end
      endcase
endmodule
